fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  load-use hold from the hazard/forwarding logic.
REQ-006 flush  input  1  squash the fetched instruction (branch or mret).
REQ-007 br_taken  input  1  branch/jump resolved taken in execute.
REQ-008 br_target  input  32  branch/jump target address.
REQ-009 flush_mret  input  1  mret executed; redirect to epc.
REQ-010 epc  input  32  mret return address.
REQ-011 imem_req  output  1  instruction memory request.
REQ-012 imem_addr  output  32  word-aligned fetch address.
REQ-013 imem_ack  input  1  memory accepted request; imem_rdata valid this cycle.
REQ-014 imem_rdata  input  32  instruction word.
REQ-015 instr_F  output  32  instruction presented to decode/hazard logic.
REQ-016 pc_F  output  32  PC of instr_F.
REQ-017 valid_F  output  1  instr_F is a real instruction, not a bubble.

Function
REQ-018 FSM states: S_BOOT, S_FETCH, S_HOLD.
- S_BOOT: imem_req=0; next cycle -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc.
- S_HOLD: imem_req=0.
REQ-019 In S_FETCH with imem_ack=1 and no stall/flush: instr_F<=imem_rdata, pc_F<=pc, valid_F<=1, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0).
REQ-020 In S_FETCH with imem_ack=0 and no stall/flush: outputs hold, imem_addr held stable, state unchanged.
REQ-021 stall=1 (flush=0): instr_F, pc_F, valid_F, pc frozen; imem_req=0; any imem_ack ignored; S_FETCH->S_HOLD; S_HOLD->S_FETCH on first cycle with stall=0.
REQ-022 Redirect priority: flush_mret > br_taken; next pc = epc if flush_mret else br_target.
REQ-023 flush=1 or a redirect: instr_F<=NOP_INSTR, valid_F<=0 next cycle, pc<=redirect target, state->S_FETCH; same-cycle imem_ack data discarded.
REQ-024 flush together with stall: flush wins; stall ignored that cycle.
REQ-025 Redirect in the same cycle as imem_ack: acked data discarded; the target is fetched from the next cycle on.
REQ-026 imem_addr[1:0] always 2'b00; redirect targets have bits [1:0] forced to 0.
REQ-027 Latency: instruction appears on instr_F the cycle after its imem_ack.

Reset
REQ-028 On rst_n=0, immediately: state=S_BOOT, pc=RESET_PC, instr_F=NOP_INSTR, pc_F=RESET_PC, valid_F=0, imem_req=0.
REQ-029 First request (addr RESET_PC) issued in the second cycle after rst_n deasserts.
REQ-030 Reset asserted mid-request abandons the request with no residual state.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], reset 0. These count cycles with stall=1, flush=0 and cycles with flush=1 respectively, and wrap at 2^32.
REQ-032 FETCH_PERF_CNT_EN undefined: ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 Shared package riscv_pkg holds the fetch_state_e typedef (S_BOOT/S_FETCH/S_HOLD), the NOP_INSTR constant and the RESET_PC default.
REQ-034 Sub-module fetch_perf_cnt holds both counters and is instantiated only under FETCH_PERF_CNT_EN; all other logic is flat.

Verification
REQ-035 Reset release with imem_ack tied to 1 and rdata = address-tagged words -> addresses 0,4,8 requested; instr_F follows one cycle later; valid_F=1 from the third cycle.
REQ-036 stall=1 for 2 cycles after instr at pc 8 -> instr_F/pc_F hold pc 8; imem_req=0; fetch resumes at 0xC.
REQ-037 br_taken=1, flush=1, br_target=0x100 while imem_ack=1 -> next cycle instr_F=0x13, valid_F=0; the following fetch is at 0x100.
REQ-038 flush_mret=1 and br_taken=1 together, epc=0x80, br_target=0x200 -> redirect to 0x80.
REQ-039 stall=1 and flush=1 together -> flush behaviour per REQ-023; no hold.
REQ-040 RESET_PC=0xFFFF_FFFC -> second fetch at 0x0; with FETCH_PERF_CNT_EN, 3 stall cycles plus 1 flush -> counters 3 and 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM state encoding and reset/bubble constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: stalled cycles (stall without flush) and flushed cycles.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (stall && !flush) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush)           r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall/flush/redirect handling, one-cycle imem latency.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush_mret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic        valid_F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_f;
    logic        r_valid;

    logic        w_redirect;
    logic        w_squash;
    logic        w_stall;
    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_target_al;

    // Any squash source overrides stall; mret outranks a taken branch.
    assign w_redirect  = br_taken | flush_mret;
    assign w_squash    = flush | w_redirect;
    assign w_stall     = stall & ~w_squash;
    assign w_target    = flush_mret ? epc : br_target;
    assign w_target_al = w_target & 32'hFFFF_FFFC;
    assign w_accept    = (r_state == S_FETCH) && !w_stall && !w_squash && imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BOOT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = w_stall ? S_HOLD : S_FETCH;
            S_HOLD:  w_state_nxt = w_stall ? S_HOLD : S_FETCH;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req = (r_state == S_FETCH) && !w_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC_AL;
            r_instr <= NOP_INSTR;
            r_pc_f  <= RESET_PC;
            r_valid <= 1'b0;
        end else if (w_squash) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (w_redirect) r_pc <= w_target_al;
        end else if (w_accept) begin
            r_instr <= imem_rdata;
            r_pc_f  <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + 32'd4;
        end
    end

    // imem_addr only changes on accept or redirect, so it is stable while waiting for ack.
    assign imem_addr = r_pc;
    assign instr_F   = r_instr;
    assign pc_F      = r_pc_f;
    assign valid_F   = r_valid;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-reset instance plus a RESET_PC=0xFFFF_FFFC instance.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, br_taken, flush_mret, imem_ack;
    logic [31:0] br_target, epc, imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, instr_F, pc_F;
    logic        valid_F;

    logic        stall_b, flush_b;
    logic        imem_req_b;
    logic [31:0] imem_addr_b, imem_rdata_b, instr_F_b, pc_F_b;
    logic        valid_F_b;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign imem_rdata   = 32'hC000_0000 | imem_addr;
    assign imem_rdata_b = 32'hC000_0000 | imem_addr_b;

    fetch_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .flush_mret (flush_mret),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_F    (instr_F),
        .pc_F       (pc_F),
        .valid_F    (valid_F)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (stall_cnt_a),
        .perf_flush_cnt (flush_cnt_a)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall_b),
        .flush      (flush_b),
        .br_taken   (1'b0),
        .br_target  (32'h0),
        .flush_mret (1'b0),
        .epc        (32'h0),
        .imem_req   (imem_req_b),
        .imem_addr  (imem_addr_b),
        .imem_ack   (1'b1),
        .imem_rdata (imem_rdata_b),
        .instr_F    (instr_F_b),
        .pc_F       (pc_F_b),
        .valid_F    (valid_F_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (stall_cnt_b),
        .perf_flush_cnt (flush_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; flush_mret = 1'b0;
        br_target = 32'h0; epc = 32'h0; imem_ack = 1'b1; stall_b = 1'b0; flush_b = 1'b0;
        #12;
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_instr",  instr_F, 32'h0000_0013);
        chk("rst_pcF",    pc_F, 32'h0);
        chk("rst_valid",  {31'd0, valid_F}, 32'd0);
        chk("rst_pcF_b",  pc_F_b, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;

        tick();  // boot -> fetch
        chk("e1_req",    {31'd0, imem_req}, 32'd1);
        chk("e1_addr",   imem_addr, 32'h0);
        chk("e1_valid",  {31'd0, valid_F}, 32'd0);
        chk("e1_addr_b", imem_addr_b, 32'hFFFF_FFFC);

        tick();
        chk("e2_instr",  instr_F, 32'hC000_0000);
        chk("e2_valid",  {31'd0, valid_F}, 32'd1);
        chk("e2_addr",   imem_addr, 32'h4);
        chk("e2_pcF_b",  pc_F_b, 32'hFFFF_FFFC);
        chk("e2_wrap_b", imem_addr_b, 32'h0);
        stall_b = 1'b1;

        tick();
        chk("e3_instr",  instr_F, 32'hC000_0004);
        chk("e3_addr",   imem_addr, 32'h8);

        tick();
        chk("e4_instr",  instr_F, 32'hC000_0008);
        chk("e4_pcF",    pc_F, 32'h8);
        chk("e4_addr",   imem_addr, 32'hC);
        stall = 1'b1;
        #1;
        chk("stall_req", {31'd0, imem_req}, 32'd0);

        tick();
        chk("hold1_instr", instr_F, 32'hC000_0008);
        chk("hold1_req",   {31'd0, imem_req}, 32'd0);
        stall_b = 1'b0; flush_b = 1'b1;

        tick();
        chk("hold2_pcF",   pc_F, 32'h8);
        chk("hold2_valid", {31'd0, valid_F}, 32'd1);
        stall = 1'b0; flush_b = 1'b0;
        #1;
        chk("hold_exit_req", {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", stall_cnt_b, 32'd3);
        chk("perf_flush", flush_cnt_b, 32'd1);
        chk("perf_stall_a", stall_cnt_a, 32'd2);
`endif

        tick();
        chk("resume_req",  {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        chk("resume_instr", instr_F, 32'hC000_0008);

        tick();
        chk("e8_instr", instr_F, 32'hC000_000C);
        chk("e8_addr",  imem_addr, 32'h10);
        flush = 1'b1; br_taken = 1'b1; br_target = 32'h100;

        tick();
        chk("br_instr", instr_F, 32'h0000_0013);
        chk("br_valid", {31'd0, valid_F}, 32'd0);
        flush = 1'b0; br_taken = 1'b0;
        #1;
        chk("br_addr", imem_addr, 32'h100);

        tick();
        chk("br_tgt_instr", instr_F, 32'hC000_0100);
        chk("br_tgt_pcF",   pc_F, 32'h100);
        flush = 1'b1; br_taken = 1'b1; flush_mret = 1'b1; epc = 32'h80; br_target = 32'h200;

        tick();
        flush = 1'b0; br_taken = 1'b0; flush_mret = 1'b0;
        #1;
        chk("mret_addr",  imem_addr, 32'h80);
        chk("mret_valid", {31'd0, valid_F}, 32'd0);

        tick();
        chk("mret_instr", instr_F, 32'hC000_0080);
        stall = 1'b1; flush = 1'b1; br_taken = 1'b1; br_target = 32'h43;
        #1;
        chk("sf_req", {31'd0, imem_req}, 32'd1);

        tick();
        chk("sf_instr", instr_F, 32'h0000_0013);
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        #1;
        chk("sf_addr_align", imem_addr, 32'h40);
        chk("sf_req_after",  {31'd0, imem_req}, 32'd1);

        tick();
        chk("sf_tgt_instr", instr_F, 32'hC000_0040);
        imem_ack = 1'b0;

        tick();
        chk("noack_instr", instr_F, 32'hC000_0040);
        chk("noack_addr",  imem_addr, 32'h44);
        chk("noack_req",   {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1;

        tick();
        chk("ack_instr", instr_F, 32'hC000_0044);
        chk("ack_pcF",   pc_F, 32'h44);

        rst_n = 1'b0;
        #1;
        chk("midrst_req",   {31'd0, imem_req}, 32'd0);
        chk("midrst_instr", instr_F, 32'h0000_0013);
        chk("midrst_valid", {31'd0, valid_F}, 32'd0);
        chk("midrst_addr",  imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rerun_instr", instr_F, 32'hC000_0000);
        chk("rerun_addr",  imem_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
